code_lock_fsm: RTL and testbench
================================

Name: code_lock_fsm

Overview:
- Consumes the single-cycle press pulses from the per-button debounce/edge stages (4 buttons) and runs a combination-lock sequence checker.
- Compares an entered digit sequence against a parameterised code.
- Drives unlocked/alarm status to the display and LED logic.
- Inter-press timeout, unlock hold time, and failed-attempt lockout are all cycle-counted.

Parameters:
- CODE_LEN, 4, number of digits per attempt (legal 1..8)
- CODE, 16'h00E4, packed code, 2 bits per digit, digit 0 in bits [1:0]; only the low 2*CODE_LEN bits are used (default sequence 0,1,2,3)
- TIMEOUT_CYCLES, 500_000_000, max idle cycles between presses during entry (5 s at 100 MHz)
- UNLOCK_CYCLES, 300_000_000, cycles the unlocked output is held (3 s)
- MAX_FAILS, 3, consecutive wrong attempts that trigger lockout (legal 1..7)
- LOCKOUT_CYCLES, 1_000_000_000, alarm/lockout duration (10 s)

Ports:
- clock  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- btn_pulse  in  4  one-cycle press pulses, bit i = digit i
- unlocked  out  1  high while in UNLOCKED
- alarm  out  1  high while in LOCKOUT
- busy  out  1  high in ENTRY, CHECK, UNLOCKED, LOCKOUT
- digit_count  out  4  digits accepted in the current attempt (0..CODE_LEN)
- fail_count  out  3  consecutive failed attempts
- attempt_done  out  1  one-cycle pulse when an attempt is judged (pass or fail)

Behaviour:
- Reset (async, reset_n low): state=IDLE; all outputs 0; shift register, timer and counters cleared.
- A press is the cycle where btn_pulse != 0.
  - Exactly one bit set: valid digit, encoded to 2 bits.
  - More than one bit set: recorded as invalid digit value 2'b11 plus a sticky bad flag, which forces the attempt to fail.
- States:
  - IDLE: on press, store digit 0, digit_count=1, timer=0, go to ENTRY. If CODE_LEN==1, go straight to CHECK.
  - ENTRY:
    - Each press stores the next digit and increments digit_count; timer resets to 0.
    - On the press that makes digit_count==CODE_LEN, go to CHECK.
    - If timer reaches TIMEOUT_CYCLES-1 with no press: go to IDLE, clear digits and digit_count; fail_count unchanged (a timeout is not an attempt).
  - CHECK (exactly 1 cycle):
    - Compare stored digits with CODE[2*CODE_LEN-1:0]; bad flag forces a mismatch.
    - attempt_done=1 this cycle. Presses in this cycle are ignored.
    - Match: go to UNLOCKED, fail_count=0.
    - Mismatch: fail_count+1. If the new value == MAX_FAILS, go to LOCKOUT; else go to IDLE.
    - digit_count clears on exit.
  - UNLOCKED: unlocked=1 for exactly UNLOCK_CYCLES cycles, then IDLE. Presses ignored.
  - LOCKOUT: alarm=1 for exactly LOCKOUT_CYCLES cycles, then IDLE with fail_count=0. Presses ignored.
- Latency: last-digit press at cycle N → CHECK at N+1 (attempt_done) → unlocked/alarm high from N+2.
- Timers are 32-bit, saturate-free (bounded by their parameters); all counters wrap-free by construction.
- A press on the same cycle as timeout expiry: the press wins; it is accepted and the timer resets.
- All outputs are registered. No combinational path from btn_pulse to any output.

Optional Feature:
- Macro: CODE_LOCK_RELOCK_EN
- Defined: any press while UNLOCKED returns to IDLE on the next cycle; unlocked drops that cycle; the press is not recorded as a digit.
- Undefined: presses in UNLOCKED are ignored and the full UNLOCK_CYCLES hold always elapses.

Test Plan:
- Bench parameters: TIMEOUT=20, UNLOCK=10, LOCKOUT=15, MAX_FAILS=3.
- Correct code: pulses on bits 0,1,2,3, spaced 5 cycles apart → attempt_done at last press+1; unlocked high for exactly 10 cycles starting last press+2; fail_count=0.
- Wrong code: 0,1,2,2 → attempt_done, fail_count=1, unlocked stays 0, back to IDLE (busy=0 at last press+2).
- Lockout: three wrong attempts → fail_count=3, alarm high 15 cycles, presses during alarm ignored (digit_count stays 0), then fail_count=0.
- Timeout: press 0, then 20 idle cycles → digit_count returns to 0, fail_count unchanged; subsequent correct code unlocks.
- Multi-bit press: btn_pulse=4'b0011 as digit 2 of an otherwise correct code → attempt fails, fail_count=1.
- Reset mid-operation: reset_n low during UNLOCKED → unlocked=0 immediately (asynchronous), state IDLE, all counters 0.

Source files
------------

// File: rtl/code_lock_fsm.sv
// Combination-lock sequence checker fed by 4 single-cycle button press pulses.
// Optional macro CODE_LOCK_RELOCK_EN: any press while unlocked relocks immediately.
module code_lock_fsm #(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [15:0] CODE           = 16'h00E4,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned UNLOCK_CYCLES  = 300_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] btn_pulse,
  output logic       unlocked,
  output logic       alarm,
  output logic       busy,
  output logic [3:0] digit_count,
  output logic [2:0] fail_count,
  output logic       attempt_done,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  localparam logic [15:0] CODE_MASK    = 16'((32'd1 << (2 * CODE_LEN)) - 32'd1);
  localparam logic [3:0]  LEN          = 4'(CODE_LEN);
  localparam logic [2:0]  FAIL_LIMIT   = 3'(MAX_FAILS);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] UNLOCK_LAST  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LAST = 32'(LOCKOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  fails_q, fails_d;
  logic        bad_q, bad_d;
  logic [31:0] timer_q, timer_d;
  logic        unlocked_q, alarm_q, busy_q, done_q;

  logic       press;
  logic       one_hot;
  logic [1:0] press_digit;
  logic       code_match;

  assign press      = |btn_pulse;
  assign one_hot    = $onehot(btn_pulse);
  assign code_match = !bad_q && ((digits_q & CODE_MASK) == (CODE & CODE_MASK));

  // Multi-bit presses encode as 3; the sticky bad flag is what forces the failure.
  always_comb begin
    press_digit = 2'd3;
    case (btn_pulse)
      4'b0001: press_digit = 2'd0;
      4'b0010: press_digit = 2'd1;
      4'b0100: press_digit = 2'd2;
      4'b1000: press_digit = 2'd3;
      default: press_digit = 2'd3;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    fails_d  = fails_q;
    bad_d    = bad_q;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          digits_d      = '0;
          digits_d[1:0] = press_digit;
          bad_d         = !one_hot;
          count_d       = 4'd1;
          timer_d       = '0;
          state_d       = (LEN == 4'd1) ? S_CHECK : S_ENTRY;
        end
      end
      S_ENTRY: begin
        // A press on the expiry cycle takes priority over the timeout.
        if (press) begin
          digits_d[{count_q[2:0], 1'b0} +: 2] = press_digit;
          bad_d   = bad_q | !one_hot;
          count_d = count_q + 4'd1;
          timer_d = '0;
          if (count_q + 4'd1 == LEN) state_d = S_CHECK;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d  = S_IDLE;
          digits_d = '0;
          count_d  = '0;
          bad_d    = 1'b0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_CHECK: begin
        digits_d = '0;
        count_d  = '0;
        bad_d    = 1'b0;
        timer_d  = '0;
        if (code_match) begin
          fails_d = '0;
          state_d = S_UNLOCKED;
        end else begin
          fails_d = fails_q + 3'd1;
          state_d = (fails_q + 3'd1 == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_UNLOCKED: begin
        if (timer_q == UNLOCK_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
`ifdef CODE_LOCK_RELOCK_EN
        if (press) begin
          state_d = S_IDLE;
          timer_d = '0;
        end
`endif
      end
      S_LOCKOUT: begin
        if (timer_q == LOCKOUT_LAST) begin
          state_d = S_IDLE;
          fails_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        digits_d = '0;
        count_d  = '0;
        bad_d    = 1'b0;
        timer_d  = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      count_q    <= '0;
      fails_q    <= '0;
      bad_q      <= 1'b0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      fails_q    <= fails_d;
      bad_q      <= bad_d;
      timer_q    <= timer_d;
      unlocked_q <= (state_d == S_UNLOCKED);
      alarm_q    <= (state_d == S_LOCKOUT);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_CHECK);
    end
  end

  assign unlocked     = unlocked_q;
  assign alarm        = alarm_q;
  assign busy         = busy_q;
  assign digit_count  = count_q;
  assign fail_count   = fails_q;
  assign attempt_done = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: directed scenarios plus random presses against an
// event-time reference model (windows and deadlines in absolute edge numbers).
module tb_code_lock_fsm;

  localparam int          CODE_LEN = 4;
  localparam logic [15:0] CODE     = 16'h00E4;
  localparam int          T_OUT    = 20;
  localparam int          T_UNL    = 10;
  localparam int          T_LCK    = 15;
  localparam int          MF       = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn_pulse = '0;
  logic       unlocked, alarm, busy, attempt_done;
  logic [3:0] digit_count;
  logic [2:0] fail_count;
  logic [2:0] dbg_state;

  code_lock_fsm #(
    .CODE_LEN(CODE_LEN), .CODE(CODE), .TIMEOUT_CYCLES(T_OUT),
    .UNLOCK_CYCLES(T_UNL), .MAX_FAILS(MF), .LOCKOUT_CYCLES(T_LCK)
  ) dut (
    .clock(clock), .reset_n(reset_n), .btn_pulse(btn_pulse),
    .unlocked(unlocked), .alarm(alarm), .busy(busy),
    .digit_count(digit_count), .fail_count(fail_count),
    .attempt_done(attempt_done), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // reference model: entered digits plus absolute-edge windows for each effect
  logic [1:0] m_dig[$];
  bit m_bad;
  int m_last, m_accept, m_done;
  int m_unl_lo, m_unl_hi, m_alm_lo, m_alm_hi;
  int m_fset_edge, m_fset_val, m_fclr_edge, m_fails;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int code_digit(input int i);
    logic [15:0] c;
    c = CODE >> (2 * i);
    return int'(c & 16'h3);
  endfunction

  task automatic model_reset();
    m_dig.delete();
    m_bad = 0; m_fails = 0; m_last = 0; m_accept = 0; m_done = -1;
    m_unl_lo = 1; m_unl_hi = 0; m_alm_lo = 1; m_alm_hi = 0;
    m_fset_edge = -1; m_fset_val = 0; m_fclr_edge = -1;
  endtask

  task automatic judge(input int e);
    bit ok;
    int nf;
    ok = !m_bad;
    for (int i = 0; i < CODE_LEN; i++) if (int'(m_dig[i]) != code_digit(i)) ok = 0;
    m_dig.delete();
    m_bad = 0;
    m_done = e;
    m_fset_edge = e + 1;
    if (ok) begin
      m_fset_val = 0;
      m_unl_lo = e + 1; m_unl_hi = e + T_UNL;
      m_accept = e + T_UNL + 2;
    end else begin
      nf = m_fails + 1;
      m_fset_val = nf;
      if (nf == MF) begin
        m_alm_lo = e + 1; m_alm_hi = e + T_LCK;
        m_accept = e + T_LCK + 2;
        m_fclr_edge = e + T_LCK + 1;
      end else begin
        m_accept = e + 2;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] b);
    int d;
    if (edge_n == m_fset_edge) m_fails = m_fset_val;
    if (edge_n == m_fclr_edge) m_fails = 0;
    if (b != 4'd0 && edge_n >= m_accept) begin
      if ($countones(b) == 1) begin
        d = 0;
        for (int i = 0; i < 4; i++) if (b[i]) d = i;
        m_dig.push_back(2'(d));
      end else begin
        m_dig.push_back(2'd3);
        m_bad = 1;
      end
      m_last = edge_n;
      if (m_dig.size() == CODE_LEN) judge(edge_n);
    end else if (m_dig.size() > 0 && edge_n - m_last == T_OUT) begin
      m_dig.delete();
      m_bad = 0;
    end
  endtask

  task automatic check_outputs();
    bit ad, un, al;
    ad = (edge_n == m_done);
    un = (edge_n >= m_unl_lo) && (edge_n <= m_unl_hi);
    al = (edge_n >= m_alm_lo) && (edge_n <= m_alm_hi);
    check_eq("attempt_done", 32'(attempt_done), 32'(ad));
    check_eq("unlocked", 32'(unlocked), 32'(un));
    check_eq("alarm", 32'(alarm), 32'(al));
    check_eq("busy", 32'(busy), 32'(ad || un || al || (m_dig.size() > 0)));
    check_eq("digit_count", 32'(digit_count), ad ? 32'(CODE_LEN) : 32'(m_dig.size()));
    check_eq("fail_count", 32'(fail_count), 32'(m_fails));
  endtask

  // driver: present b for one clock edge, advance the model, check at the negedge
  task automatic step(input logic [3:0] b);
    btn_pulse = b;
    @(posedge clock);
    edge_n++;
    model_step(b);
    @(negedge clock);
    btn_pulse = '0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0);
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3, input int gap);
    int ds[4];
    ds = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      step(4'b0001 << ds[i]);
      if (i < 3) idle(gap);
    end
  endtask

  task automatic random_step();
    int r;
    int d;
    logic [3:0] b;
    r = $urandom_range(0, 20);
    if (r == 20) begin
      idle($urandom_range(15, 25));
    end else begin
      b = '0;
      if (r >= 14 && r < 18) begin
        d = ($urandom_range(0, 1) == 1) ? code_digit(m_dig.size() % CODE_LEN) : $urandom_range(0, 3);
        b = 4'b0001 << d;
      end else if (r >= 18) begin
        b = 4'($urandom_range(1, 15));
      end
      step(b);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
    idle(2);

    // correct code, presses 5 cycles apart
    enter_code(0, 1, 2, 3, 4);
    idle(14);
    // wrong code
    enter_code(0, 1, 2, 2, 4);
    idle(3);
    // two more wrong attempts reach lockout; presses during alarm are ignored
    enter_code(3, 3, 3, 3, 1);
    idle(2);
    enter_code(1, 0, 2, 3, 0);
    for (int i = 0; i < 16; i++) step(4'($urandom_range(0, 15)));
    idle(3);
    // timeout, then correct code
    step(4'b0001);
    idle(20);
    enter_code(0, 1, 2, 3, 2);
    idle(13);
    // press on the timeout-expiry edge is accepted
    step(4'b0001);
    idle(19);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    idle(13);
    // multi-bit press as digit 2
    step(4'b0001);
    step(4'b0010);
    step(4'b0011);
    step(4'b1000);
    idle(4);

    for (int i = 0; i < 700; i++) random_step();
    idle(40);

    // asynchronous reset while unlocked
    enter_code(0, 1, 2, 3, 1);
    idle(3);
    check_eq("pre_reset_unlocked", 32'(unlocked), 32'd1);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    enter_code(0, 1, 2, 3, 0);
    idle(14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
